// File: rtl/calc_defs_pkg.sv
// Shared definitions for the calculator datapath blocks: FSM state
// encodings and the iteration-counter width helper.
package calc_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter width able to hold the values 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_shift_add_mult.sv
// Iterative shift-add multiplier: one multiplier bit per clock.
// Signed operands are handled as sign-magnitude. The magnitudes are
// multiplied unsigned, and the product is negated at the end when the
// operand signs differ.
module seq_shift_add_mult
  import calc_defs::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [WIDTH-1:0] mc_q, mc_d;
  logic [WIDTH-1:0] mp_q, mp_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    prod_q, prod_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_sum;

  // Operand conditioning. The most negative value maps to 2^(WIDTH-1),
  // which still fits in WIDTH unsigned bits.
  always_comb begin
    a_neg = signed_mode & multiplicand[WIDTH-1];
    b_neg = signed_mode & multiplier[WIDTH-1];
    a_mag = a_neg ? (~multiplicand + WIDTH'(1)) : multiplicand;
    b_mag = b_neg ? (~multiplier + WIDTH'(1)) : multiplier;
  end

  // One partial product per iteration. The product magnitude is below
  // 2^(2*WIDTH), so the add never carries out.
  assign addend  = mp_q[0] ? ({{WIDTH{1'b0}}, mc_q} << cnt_q) : '0;
  assign acc_sum = acc_q + addend;

  // Next-state and datapath update. A start is accepted in IDLE or DONE.
  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    mp_d    = mp_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    prod_d  = prod_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          mc_d    = a_mag;
          mp_d    = b_mag;
          neg_d   = a_neg ^ b_neg;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d = acc_sum;
        mp_d  = mp_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          // The result is registered on the edge that enters DONE, so it
          // is valid during the same cycle that done is high.
          state_d = ST_DONE;
          prod_d  = neg_q ? (~acc_sum + PW'(1)) : acc_sum;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers. Reset aborts any operation in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mc_q    <= '0;
      mp_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
      mp_q    <= mp_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign product = prod_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed testbench for seq_shift_add_mult.
// Instance dut4 uses WIDTH=4 and instance dut8 uses WIDTH=8.
module tb_seq_shift_add_mult;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       signed_mode;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  logic        start8;
  logic        sm8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [15:0] product8;

  int checks = 0;
  int errors = 0;

  seq_shift_add_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .multiplicand(a), .multiplier(b), .busy(busy), .done(done), .product(product)
  );

  seq_shift_add_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .multiplicand(a8), .multiplier(b8), .busy(busy8), .done(done8), .product(product8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Launch one WIDTH=4 operation. On return the accepting edge has passed.
  task automatic launch(input logic [3:0] ta, input logic [3:0] tb, input logic sm);
    a = ta; b = tb; signed_mode = sm; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Count edges, including the accepting edge, until done is seen (bounded).
  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 1;
    busy_cycles = 0;
    while (!done && edges < 20) begin
      if (busy) busy_cycles++;
      cyc();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    cyc(); cyc();
    checks++;
    if ({busy, done, product} !== 10'd0) begin
      errors++;
      $display("FAIL reset_w4: busy=%b done=%b product=%h, required 0 0 00", busy, done, product);
    end
    checks++;
    if ({busy8, done8, product8} !== 18'd0) begin
      errors++;
      $display("FAIL reset_w8: busy=%b done=%b product=%h, required 0 0 0000", busy8, done8, product8);
    end
    rst_n = 1'b1;
    cyc();
    checks++;
    if ({busy, done, product} !== 10'd0) begin
      errors++;
      $display("FAIL idle_after_release: busy=%b done=%b product=%h, required 0 0 00", busy, done, product);
    end
    $display("reset: outputs idle");
  endtask

  task automatic test_unsigned();
    int edges, bc;
    launch(4'hD, 4'hB, 1'b0);
    wait_done(edges, bc);
    checks++;
    if (edges !== 5) begin
      errors++;
      $display("FAIL unsigned_latency: done after %0d clocks, required 5", edges);
    end
    checks++;
    if (bc !== 4) begin
      errors++;
      $display("FAIL unsigned_busy: busy for %0d cycles, required 4", bc);
    end
    checks++;
    if (product !== 8'h8F) begin
      errors++;
      $display("FAIL unsigned_13x11: product=%h, required 8f", product);
    end
    cyc();
    checks++;
    if (done !== 1'b0 || product !== 8'h8F) begin
      errors++;
      $display("FAIL done_pulse_hold: done=%b product=%h, required 0 8f", done, product);
    end
    $display("unsigned 13*11: product=%h latency=%0d busy=%0d", product, edges, bc);
  endtask

  task automatic test_signed();
    logic [3:0] va  [4] = '{4'hD, 4'h8, 4'h8, 4'hF};
    logic [3:0] vb  [4] = '{4'h5, 4'h8, 4'h8, 4'hF};
    logic       vsm [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] vexp[4] = '{8'hF1, 8'h40, 8'h40, 8'hE1};
    int edges, bc;
    for (int i = 0; i < 4; i++) begin
      launch(va[i], vb[i], vsm[i]);
      wait_done(edges, bc);
      checks++;
      if (product !== vexp[i] || edges !== 5) begin
        errors++;
        $display("FAIL mode_vec%0d: product=%h latency=%0d, required %h latency 5",
                 i, product, edges, vexp[i]);
      end
      $display("vec%0d: %h*%h signed=%b product=%h", i, va[i], vb[i], vsm[i], product);
      cyc();
    end
  endtask

  task automatic test_start_in_run();
    int pulses = 0;
    logic [7:0] first_prod = '0;
    launch(4'hD, 4'h5, 1'b1);
    // New request and changed operands/mode while busy: all ignored.
    a = 4'hF; b = 4'hF; signed_mode = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (done) begin
        pulses++;
        first_prod = product;
      end
      cyc();
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL start_in_run_pulses: %0d done pulses, required 1", pulses);
    end
    checks++;
    if (first_prod !== 8'hF1) begin
      errors++;
      $display("FAIL start_in_run_product: product=%h, required f1", first_prod);
    end
    $display("start during run: pulses=%0d product=%h", pulses, first_prod);
  endtask

  task automatic test_back_to_back();
    int done_at[$];
    logic [7:0] prods[$];
    a = 4'h7; b = 4'h9; signed_mode = 1'b0; start = 1'b1;
    cyc();
    a = 4'h2; b = 4'h3;
    for (int n = 1; n <= 14; n++) begin
      if (done) begin
        done_at.push_back(n);
        prods.push_back(product);
      end
      if (n == 7) begin
        checks++;
        if (product !== 8'h3F) begin
          errors++;
          $display("FAIL hold_during_run: product=%h, required 3f", product);
        end
      end
      if (n == 6) start = 1'b0;
      cyc();
    end
    checks++;
    if (done_at.size() != 2 || done_at[0] != 5 || done_at[1] != 10) begin
      errors++;
      $display("FAIL b2b_timing: %0d pulses, first at %0d, required 2 at 5 and 10",
               done_at.size(), (done_at.size() > 0) ? done_at[0] : -1);
    end else begin
      checks++;
      if (prods[0] !== 8'h3F || prods[1] !== 8'h06) begin
        errors++;
        $display("FAIL b2b_products: %h %h, required 3f 06", prods[0], prods[1]);
      end
      $display("back-to-back: done at %0d,%0d products %h %h",
               done_at[0], done_at[1], prods[0], prods[1]);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses = 0;
    int edges, bc;
    launch(4'hD, 4'hB, 1'b0);
    cyc();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, product} !== 10'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b product=%h, required 0 0 00", busy, done, product);
    end
    cyc(); cyc();
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      if (done) pulses++;
      cyc();
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL aborted_done: %0d done pulses, required 0", pulses);
    end
    launch(4'h1, 4'h1, 1'b0);
    wait_done(edges, bc);
    checks++;
    if (product !== 8'h01 || edges !== 5) begin
      errors++;
      $display("FAIL after_reset_1x1: product=%h latency=%0d, required 01 latency 5", product, edges);
    end
    $display("reset mid-run: no done, then 1*1 product=%h", product);
    cyc();
  endtask

  task automatic test_wide();
    logic [7:0]  va  [2] = '{8'h80, 8'h00};
    logic [7:0]  vb  [2] = '{8'h7F, 8'hFF};
    logic        vsm [2] = '{1'b1, 1'b0};
    logic [15:0] vexp[2] = '{16'hC080, 16'h0000};
    int edges;
    for (int i = 0; i < 2; i++) begin
      a8 = va[i]; b8 = vb[i]; sm8 = vsm[i]; start8 = 1'b1;
      cyc();
      start8 = 1'b0;
      edges = 1;
      while (!done8 && edges < 30) begin
        cyc();
        edges++;
      end
      checks++;
      if (product8 !== vexp[i] || edges !== 9) begin
        errors++;
        $display("FAIL w8_vec%0d: product=%h latency=%0d, required %h latency 9",
                 i, product8, edges, vexp[i]);
      end
      $display("w8 vec%0d: %h*%h signed=%b product=%h latency=%0d",
               i, va[i], vb[i], vsm[i], product8, edges);
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid_run();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
